motors_cmd_issuer: RTL and testbench

- Master-side driver for the motors control interface: accepts move commands from the command pipeline, buffers them, and issues them one at a time to the motors controller.
- Drives the X/Y pulse counts and the servo position, pulses trigger, and waits for motors_done before issuing the next command.
- Sits between the command decoder/parser and the motors controller; the motors controller is the responder, this block is the initiator.

---
 rtl/motors_cmd_issuer_if.sv | 22 ++
 rtl/motors_cmd_issuer.sv | 153 +++++++++++++++
 tb/tb_motors_cmd_issuer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motors_cmd_issuer_if.sv
// Motors controller bus: issued move (counts, servo, trigger) and the controller's rdy/done replies.
interface motors_cmd_issuer_if #(
    parameter int PULSE_NUM_X_BITS = 16,
    parameter int PULSE_NUM_Y_BITS = 16
);
    logic                               motors_trigger;
    logic signed [PULSE_NUM_X_BITS-1:0] motors_pulse_x;
    logic signed [PULSE_NUM_Y_BITS-1:0] motors_pulse_y;
    logic                               motors_servo_down;
    logic                               motors_rdy;
    logic                               motors_done;

    modport master (
        output motors_trigger, motors_pulse_x, motors_pulse_y, motors_servo_down,
        input  motors_rdy, motors_done
    );

    modport slave (
        input  motors_trigger, motors_pulse_x, motors_pulse_y, motors_servo_down,
        output motors_rdy, motors_done
    );
endinterface

// File: rtl/motors_cmd_issuer.sv
// Buffers move commands in a small FIFO and issues them one at a time to the motors controller.
// Optional watchdog enabled by defining MOTORS_CMD_ISSUER_TIMEOUT_EN.
module motors_cmd_issuer #(
    parameter int PULSE_NUM_X_BITS = 16,
    parameter int PULSE_NUM_Y_BITS = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic signed [PULSE_NUM_X_BITS-1:0] cmd_pulse_x,
    input  logic signed [PULSE_NUM_Y_BITS-1:0] cmd_pulse_y,
    input  logic                               cmd_servo_down,
    motors_cmd_issuer_if.master                motors,
    output logic                               busy,
    output logic [15:0]                        cmd_count,
    output logic                               err_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic signed [PULSE_NUM_X_BITS-1:0] x;
        logic signed [PULSE_NUM_Y_BITS-1:0] y;
        logic                               servo;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, TRIG, WAIT_DONE} state_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    state_t        state, state_nxt;
    logic          full, empty, push, pop, accept, done_evt, flush, tmo_hit;
    cmd_t          out_q;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

`ifdef MOTORS_CMD_ISSUER_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        tmo_err;

    assign tmo_hit     = (tmo_cnt == 24'hFFFFFF);
    assign err_timeout = tmo_err;
    // After a timeout the block refuses new work until reset.
    assign cmd_ready   = !full && !tmo_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else if (clk_en) begin
            if (pop || accept)
                tmo_cnt <= '0;
            else if (state != IDLE)
                tmo_cnt <= tmo_cnt + 24'd1;
            if (flush)
                tmo_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
    assign cmd_ready   = !full;
`endif

    assign push = cmd_valid && cmd_ready && clk_en && !flush;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        accept    = 1'b0;
        done_evt  = 1'b0;
        flush     = 1'b0;
        if (clk_en) begin
            case (state)
                IDLE: if (!empty && motors.motors_rdy) begin
                    pop       = 1'b1;
                    state_nxt = TRIG;
                end
                TRIG: begin
                    // done here is a zero-length move finishing as it is accepted
                    if (motors.motors_done) begin
                        done_evt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (!motors.motors_rdy) begin
                        accept    = 1'b1;
                        state_nxt = WAIT_DONE;
                    end else if (tmo_hit) begin
                        flush     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (motors.motors_done) begin
                        done_evt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (tmo_hit) begin
                        flush     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{x: cmd_pulse_x, y: cmd_pulse_y, servo: cmd_servo_down};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   out_q <= '0;
        else if (pop) out_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        cmd_count <= '0;
        else if (done_evt) cmd_count <= cmd_count + 16'd1;
    end

    assign motors.motors_trigger    = (state == TRIG);
    assign motors.motors_pulse_x    = out_q.x;
    assign motors.motors_pulse_y    = out_q.y;
    assign motors.motors_servo_down = out_q.servo;
    assign busy                     = (state != IDLE) || !empty;
endmodule

// File: tb/tb_motors_cmd_issuer.sv
// Directed bench for motors_cmd_issuer: issued commands are checked against a queue of pushed commands.
module tb_motors_cmd_issuer;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clk_en = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic signed [15:0] cmd_pulse_x = '0;
    logic signed [15:0] cmd_pulse_y = '0;
    logic               cmd_servo_down = 1'b0;
    logic               busy;
    logic [15:0]        cmd_count;
    logic               err_timeout;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic               s;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    motors_cmd_issuer_if #(.PULSE_NUM_X_BITS(16), .PULSE_NUM_Y_BITS(16)) mif ();

    motors_cmd_issuer #(.PULSE_NUM_X_BITS(16), .PULSE_NUM_Y_BITS(16), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_pulse_x    (cmd_pulse_x),
        .cmd_pulse_y    (cmd_pulse_y),
        .cmd_servo_down (cmd_servo_down),
        .motors         (mif.master),
        .busy           (busy),
        .cmd_count      (cmd_count),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic signed [15:0] x, input logic signed [15:0] y, input logic s);
        cmd_valid      = 1'b1;
        cmd_pulse_x    = x;
        cmd_pulse_y    = y;
        cmd_servo_down = s;
    endtask

    task automatic apply_reset();
        reset           = 1'b0;
        clk_en          = 1'b1;
        cmd_valid       = 1'b0;
        mif.motors_rdy  = 1'b1;
        mif.motors_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic wait_trig();
        int n = 0;
        while (mif.motors_trigger !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("trig_seen", 32'(mif.motors_trigger), 32'd1);
    endtask

    task automatic check_head();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("issued_x", 32'(mif.motors_pulse_x), 32'(e.x));
            chk("issued_y", 32'(mif.motors_pulse_y), 32'(e.y));
            chk("issued_servo", 32'(mif.motors_servo_down), 32'(e.s));
        end
    endtask

    // Controller model: accept the trigger, run for 'hold' cycles, pulse done.
    task automatic serve(input int hold);
        wait_trig();
        check_head();
        mif.motors_rdy = 1'b0;
        tick();
        chk("trig_dropped", 32'(mif.motors_trigger), 32'd0);
        repeat (hold) tick();
        mif.motors_done = 1'b1;
        tick();
        mif.motors_done = 1'b0;
        mif.motors_rdy  = 1'b1;
    endtask

    initial begin
        mif.motors_rdy  = 1'b1;
        mif.motors_done = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_trig", 32'(mif.motors_trigger), 32'd0);
        chk("rst_px", 32'(mif.motors_pulse_x), 32'd0);
        chk("rst_py", 32'(mif.motors_pulse_y), 32'd0);
        chk("rst_servo", 32'(mif.motors_servo_down), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(cmd_count), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        reset = 1'b1;
        tick();

        // Single command and issue latency
        drive_cmd(16'sd100, -16'sd50, 1'b1);
        sb.push_back('{x: 16'sd100, y: -16'sd50, s: 1'b1});
        tick();
        cmd_valid = 1'b0;
        chk("lat_cycle1", 32'(mif.motors_trigger), 32'd0);
        tick();
        chk("lat_cycle2", 32'(mif.motors_trigger), 32'd1);
        check_head();
        mif.motors_rdy = 1'b0;
        tick();
        chk("single_wait_trig", 32'(mif.motors_trigger), 32'd0);
        chk("single_wait_busy", 32'(busy), 32'd1);
        repeat (9) tick();
        chk("single_hold_x", 32'(mif.motors_pulse_x), 32'(16'sd100));
        mif.motors_done = 1'b1;
        tick();
        mif.motors_done = 1'b0;
        mif.motors_rdy  = 1'b1;
        tick();
        chk("single_count", 32'(cmd_count), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // FIFO full: 4 accepted, 5th refused, then issued in order
        apply_reset();
        mif.motors_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(16'((i + 1) * 10), 16'(-(i + 1)), i[0]);
            chk($sformatf("full_ready%0d", i), 32'(cmd_ready), 32'(i < 4));
            if (i < 4) sb.push_back('{x: 16'((i + 1) * 10), y: 16'(-(i + 1)), s: i[0]});
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        chk("full_no_trig", 32'(mif.motors_trigger), 32'd0);
        mif.motors_rdy = 1'b1;
        repeat (4) serve(3);
        tick();
        tick();
        chk("full_count", 32'(cmd_count), 32'd4);
        chk("full_no_extra", 32'(mif.motors_trigger), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_sb_drained", 32'(sb.size()), 32'd0);

        // clk_en gating: one enabled cycle in four
        apply_reset();
        drive_cmd(-16'sd7, 16'sd300, 1'b0);
        sb.push_back('{x: -16'sd7, y: 16'sd300, s: 1'b0});
        tick();
        cmd_valid = 1'b0;
        clk_en    = 1'b0;
        repeat (3) tick();
        chk("gate_no_trig", 32'(mif.motors_trigger), 32'd0);
        chk("gate_busy", 32'(busy), 32'd1);
        chk("gate_x_stable", 32'(mif.motors_pulse_x), 32'd0);
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        chk("gate_trig", 32'(mif.motors_trigger), 32'd1);
        check_head();
        mif.motors_rdy = 1'b0;
        repeat (3) tick();
        chk("gate_trig_held", 32'(mif.motors_trigger), 32'd1);
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        chk("gate_accepted", 32'(mif.motors_trigger), 32'd0);
        mif.motors_done = 1'b1;
        tick();
        mif.motors_done = 1'b0;
        chk("gate_done_ignored", 32'(cmd_count), 32'd0);
        chk("gate_still_busy", 32'(busy), 32'd1);
        clk_en          = 1'b1;
        mif.motors_done = 1'b1;
        tick();
        mif.motors_done = 1'b0;
        mif.motors_rdy  = 1'b1;
        chk("gate_count", 32'(cmd_count), 32'd1);
        chk("gate_idle", 32'(busy), 32'd0);
        chk("gate_x_kept", 32'(mif.motors_pulse_x), 32'(-32'sd7));

        // Zero move, done in the same cycle as acceptance
        apply_reset();
        drive_cmd(16'sd0, 16'sd0, 1'b0);
        sb.push_back('{x: 16'sd0, y: 16'sd0, s: 1'b0});
        tick();
        cmd_valid = 1'b0;
        wait_trig();
        check_head();
        mif.motors_rdy  = 1'b0;
        mif.motors_done = 1'b1;
        tick();
        mif.motors_done = 1'b0;
        mif.motors_rdy  = 1'b1;
        chk("zero_count", 32'(cmd_count), 32'd1);
        chk("zero_trig_low", 32'(mif.motors_trigger), 32'd0);
        repeat (4) tick();
        chk("zero_no_retrig", 32'(mif.motors_trigger), 32'd0);
        chk("zero_count_once", 32'(cmd_count), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);

        // Reset in WAIT_DONE with 3 commands queued
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cmd(16'(200 + i), 16'(-300 - i), 1'b1);
            sb.push_back('{x: 16'(200 + i), y: 16'(-300 - i), s: 1'b1});
            tick();
        end
        cmd_valid = 1'b0;
        wait_trig();
        check_head();
        mif.motors_rdy = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_wait", 32'(mif.motors_trigger), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_px", 32'(mif.motors_pulse_x), 32'd0);
        chk("mid_rst_servo", 32'(mif.motors_servo_down), 32'd0);
        tick();
        reset = 1'b1;
        sb.delete();
        mif.motors_rdy  = 1'b1;
        mif.motors_done = 1'b1;
        tick();
        mif.motors_done = 1'b0;
        repeat (3) tick();
        chk("mid_done_ignored", 32'(cmd_count), 32'd0);
        chk("mid_no_trig", 32'(mif.motors_trigger), 32'd0);
        chk("mid_fifo_empty", 32'(busy), 32'd0);

`ifdef MOTORS_CMD_ISSUER_TIMEOUT_EN
        // Watchdog: counter pushed near terminal value, done never arrives
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cmd(16'(5 + i), 16'(6 + i), 1'b0);
            sb.push_back('{x: 16'(5 + i), y: 16'(6 + i), s: 1'b0});
            tick();
        end
        cmd_valid = 1'b0;
        wait_trig();
        check_head();
        mif.motors_rdy = 1'b0;
        tick();
        force dut.tmo_cnt = 24'hFFFFFC;
        #1;
        release dut.tmo_cnt;
        begin
            int n = 0;
            while (err_timeout !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
        end
        chk("tmo_err", 32'(err_timeout), 32'd1);
        chk("tmo_ready", 32'(cmd_ready), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_trig", 32'(mif.motors_trigger), 32'd0);
        chk("tmo_count", 32'(cmd_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
